// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the rv32i fetch/data memory arbiter.
//   owner_t          : which port the read response arriving next cycle belongs to
//   STARVE_LIMIT_MAX : largest supported fetch-starvation threshold
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int STARVE_LIMIT_MAX = 15;

endpackage

// File: rtl/register.sv
// Generic capture register with synchronous active-high reset and load enable.
//   clk : clock
//   rst : synchronous reset, clears q to zero
//   ena : load enable, q <= d when high
//   d   : data in (WIDTH bits)
//   q   : registered data out (WIDTH bits)
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-ported, synchronous-read memory between the core's
// fetch port and data port. One grant per cycle; data wins unless fetch has
// been denied STARVE_LIMIT consecutive cycles. Read data (1-cycle latency) is
// routed back to the port that issued the read.
//   clk, rst                     : clock, synchronous active-high reset
//   ena                          : global enable, low = issue nothing new
//   if_req/if_addr               : fetch request and address
//   if_rd_data/if_rvalid/if_stall: fetch response word, response strobe, stall
//   dm_req/dm_wr_ena/dm_addr/dm_wr_data : data access request (store when dm_wr_ena)
//   dm_rd_data/dm_rvalid/dm_stall: load response word, response strobe, stall
//   mem_addr/mem_wr_data/mem_wr_ena : shared memory command
//   mem_rd_data                  : memory read data, valid one cycle after issue
module rv32i_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rd_data,
    output logic        if_rvalid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr_ena,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wr_data,
    output logic [31:0] dm_rd_data,
    output logic        dm_rvalid,
    output logic        dm_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    owner_t           resp_owner_reg;
    owner_t           resp_owner_next;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             grant_if;
    logic             grant_dm;
    logic             starve_hit;

    // Index 0 = fetch port, index 1 = data port.
    logic [1:0]        cap_ena;
    logic [1:0][31:0]  cap_q;

    always_comb begin
        grant_if        = 1'b0;
        grant_dm        = 1'b0;
        mem_addr        = '0;
        mem_wr_data     = '0;
        mem_wr_ena      = 1'b0;
        resp_owner_next = OWN_NONE;
        starve_cnt_next = starve_cnt_reg;

        starve_hit = if_req && (starve_cnt_reg == LIMIT_C);

        // Reset suppresses all grants so stalls mirror the requests.
        if (!rst && ena) begin
            grant_dm = dm_req && !starve_hit;
            grant_if = if_req && !grant_dm;
        end

        if_stall = if_req && !grant_if;
        dm_stall = dm_req && !grant_dm;

        if (grant_dm) begin
            mem_addr    = dm_addr;
            mem_wr_ena  = dm_wr_ena;
            mem_wr_data = dm_wr_data;
        end else if (grant_if) begin
            mem_addr    = if_addr;
        end

        // Stores complete in the grant cycle and expect no response.
        if (grant_if) begin
            resp_owner_next = OWN_IF;
        end else if (grant_dm && !dm_wr_ena) begin
            resp_owner_next = OWN_DM;
        end

        // Counter freezes while disabled so a pause does not reset fairness.
        if (ena) begin
            if (!if_req || grant_if) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg != LIMIT_C) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end

        // Decode of registered owner; masked in reset to drop in-flight data.
        if_rvalid = !rst && (resp_owner_reg == OWN_IF);
        dm_rvalid = !rst && (resp_owner_reg == OWN_DM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner_reg <= OWN_NONE;
            starve_cnt_reg <= '0;
        end else begin
            resp_owner_reg <= resp_owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign cap_ena[0] = if_rvalid;
    assign cap_ena[1] = dm_rvalid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_capture
            register #(
                .WIDTH(32)
            ) u_capture (
                .clk(clk),
                .rst(rst),
                .ena(cap_ena[gi]),
                .d  (mem_rd_data),
                .q  (cap_q[gi])
            );
        end
    endgenerate

    // Forward the word in its response cycle, then serve the held copy.
    assign if_rd_data = if_rvalid ? mem_rd_data : cap_q[0];
    assign dm_rd_data = dm_rvalid ? mem_rd_data : cap_q[1];

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
module tb_rv32i_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rd_data;
    logic        if_rvalid;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_wr_ena = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wr_data = '0;
    logic [31:0] dm_rd_data;
    logic        dm_rvalid;
    logic        dm_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .if_req(if_req), .if_addr(if_addr), .if_rd_data(if_rd_data),
        .if_rvalid(if_rvalid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr_ena(dm_wr_ena), .dm_addr(dm_addr),
        .dm_wr_data(dm_wr_data), .dm_rd_data(dm_rd_data),
        .dm_rvalid(dm_rvalid), .dm_stall(dm_stall),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .mem_rd_data(mem_rd_data)
    );

    // Behavioural single-port synchronous-read memory, 256 words.
    logic [31:0] mem_words [256];
    logic        preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_words[i] <= 32'hA000_0000 + i;
        end else if (mem_wr_ena) begin
            mem_words[mem_addr[9:2]] <= mem_wr_data;
        end
        mem_rd_data <= mem_words[mem_addr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd);
        rst = r; ena = e; if_req = ir; if_addr = ia;
        dm_req = dr; dm_wr_ena = dw; dm_addr = da; dm_wr_data = dd;
    endtask

    task automatic compare_all(input string tag, input logic e_ifs, input logic e_dms,
                               input logic [31:0] e_addr, input logic [31:0] e_wd,
                               input logic e_wr, input logic e_ifv, input logic e_dmv,
                               input logic chk_data, input logic [31:0] e_ifd,
                               input logic [31:0] e_dmd);
        chk({tag, " if_stall"}, 32'(if_stall), 32'(e_ifs));
        chk({tag, " dm_stall"}, 32'(dm_stall), 32'(e_dms));
        chk({tag, " mem_addr"}, mem_addr, e_addr);
        chk({tag, " mem_wr_data"}, mem_wr_data, e_wd);
        chk({tag, " mem_wr_ena"}, 32'(mem_wr_ena), 32'(e_wr));
        chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'(e_ifv));
        chk({tag, " dm_rvalid"}, 32'(dm_rvalid), 32'(e_dmv));
        if (chk_data) begin
            chk({tag, " if_rd_data"}, if_rd_data, e_ifd);
            chk({tag, " dm_rd_data"}, dm_rd_data, e_dmd);
        end
    endtask

    typedef struct {
        logic        r, e, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        x_ifs, x_dms;
        logic [31:0] x_addr, x_wd;
        logic        x_wr, x_ifv, x_dmv, x_chk;
        logic [31:0] x_ifd, x_dmd;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic r, input logic e, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic x_ifs, input logic x_dms,
                                input logic [31:0] x_addr, input logic [31:0] x_wd,
                                input logic x_wr, input logic x_ifv, input logic x_dmv,
                                input logic x_chk, input logic [31:0] x_ifd,
                                input logic [31:0] x_dmd);
        vec_t v;
        v.r = r; v.e = e; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.x_ifs = x_ifs; v.x_dms = x_dms; v.x_addr = x_addr; v.x_wd = x_wd; v.x_wr = x_wr;
        v.x_ifv = x_ifv; v.x_dmv = x_dmv; v.x_chk = x_chk; v.x_ifd = x_ifd; v.x_dmd = x_dmd;
        return v;
    endfunction

    // Reference model state for the random phase.
    logic [31:0] shadow [256];
    int          m_pend;       // 0 none, 1 fetch, 2 data
    logic [31:0] m_pend_data;
    logic [31:0] m_if_data;
    logic [31:0] m_dm_data;
    int          m_starve;

    initial begin
        // rst  ena ifr if_addr dmr dw dm_addr  wdata | ifs dms mem_addr  wd  wr ifv dmv chk if_data dm_data
        vecs[0]  = mk(1,1,1,32'h0, 0,0,32'h0,  32'h0,       1,0,32'h0,  32'h0,       0,0,0,0,32'h0,        32'h0);
        vecs[1]  = mk(0,1,1,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,0,0,1,32'h0,        32'h0);
        vecs[2]  = mk(0,1,1,32'h4, 0,0,32'h0,  32'h0,       0,0,32'h4,  32'h0,       0,1,0,1,32'hA0000000, 32'h0);
        vecs[3]  = mk(0,1,1,32'h8, 0,0,32'h0,  32'h0,       0,0,32'h8,  32'h0,       0,1,0,1,32'hA0000001, 32'h0);
        vecs[4]  = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,1,0,1,32'hA0000002, 32'h0);
        vecs[5]  = mk(0,1,1,32'h10,1,0,32'h100,32'h0,       1,0,32'h100,32'h0,       0,0,0,1,32'hA0000002, 32'h0);
        vecs[6]  = mk(0,1,1,32'h10,0,0,32'h0,  32'h0,       0,0,32'h10, 32'h0,       0,0,1,1,32'hA0000002, 32'hA0000040);
        vecs[7]  = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,1,0,1,32'hA0000004, 32'hA0000040);
        vecs[8]  = mk(0,1,0,32'h0, 1,1,32'h200,32'hDEADBEEF,0,0,32'h200,32'hDEADBEEF,1,0,0,1,32'hA0000004, 32'hA0000040);
        vecs[9]  = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,0,0,1,32'hA0000004, 32'hA0000040);
        vecs[10] = mk(0,1,0,32'h0, 1,0,32'h200,32'h0,       0,0,32'h200,32'h0,       0,0,0,1,32'hA0000004, 32'hA0000040);
        vecs[11] = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,0,1,1,32'hA0000004, 32'hDEADBEEF);
        vecs[12] = mk(0,1,1,32'h8, 0,0,32'h0,  32'h0,       0,0,32'h8,  32'h0,       0,0,0,1,32'hA0000004, 32'hDEADBEEF);
        vecs[13] = mk(0,0,1,32'hC, 1,0,32'h4,  32'h0,       1,1,32'h0,  32'h0,       0,1,0,1,32'hA0000002, 32'hDEADBEEF);
        vecs[14] = mk(0,0,1,32'hC, 1,0,32'h4,  32'h0,       1,1,32'h0,  32'h0,       0,0,0,1,32'hA0000002, 32'hDEADBEEF);
        vecs[15] = mk(0,1,1,32'h4, 0,0,32'h0,  32'h0,       0,0,32'h4,  32'h0,       0,0,0,1,32'hA0000002, 32'hDEADBEEF);
        vecs[16] = mk(1,1,1,32'hC, 1,1,32'h8,  32'h1234,    1,1,32'h0,  32'h0,       0,0,0,0,32'h0,        32'h0);
        vecs[17] = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,0,0,1,32'h0,        32'h0);
        vecs[18] = mk(0,1,1,32'hC, 0,0,32'h0,  32'h0,       0,0,32'hC,  32'h0,       0,0,0,1,32'h0,        32'h0);
        vecs[19] = mk(0,1,0,32'h0, 0,0,32'h0,  32'h0,       0,0,32'h0,  32'h0,       0,1,0,1,32'hA0000003, 32'h0);

        @(posedge clk);
        #1 preload = 1'b0;

        // Directed table: fetch stream, collision, store/load, ena=0, reset with read in flight.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].r, vecs[i].e, vecs[i].ir, vecs[i].ia,
                  vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            #1;
            compare_all($sformatf("row%0d", i), vecs[i].x_ifs, vecs[i].x_dms, vecs[i].x_addr,
                        vecs[i].x_wd, vecs[i].x_wr, vecs[i].x_ifv, vecs[i].x_dmv,
                        vecs[i].x_chk, vecs[i].x_ifd, vecs[i].x_dmd);
            $display("row %0d: if_stall=%0b dm_stall=%0b mem_addr=%h if_rv=%0b dm_rv=%0b",
                     i, if_stall, dm_stall, mem_addr, if_rvalid, dm_rvalid);
        end

        // Starvation: both requesting; fetch wins every (LIMIT+1)-th cycle of a streak.
        // Streak of 13, reset, then a streak of 5 to show the counter restarted from zero.
        begin
            int streak;
            streak = 0;
            for (int c = 0; c < 19; c++) begin
                logic r;
                logic exp_if_win;
                r = (c == 13);
                @(posedge clk); #1;
                drive(r, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
                #1;
                if (r) begin
                    exp_if_win = 1'b0;
                    streak = 0;
                end else begin
                    streak++;
                    exp_if_win = (streak % (LIMIT + 1)) == 0;
                end
                chk($sformatf("starve%0d if_stall", c), 32'(if_stall), 32'(!exp_if_win));
                chk($sformatf("starve%0d dm_stall", c), 32'(dm_stall), 32'(r || exp_if_win));
                $display("starve cycle %0d: rst=%0b if_stall=%0b dm_stall=%0b", c, r, if_stall, dm_stall);
            end
        end

        // Random phase against the reference model.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) shadow[i] = mem_words[i];
        m_pend = 0; m_pend_data = '0; m_if_data = '0; m_dm_data = '0; m_starve = 0;

        for (int c = 0; c < 400; c++) begin
            logic        r, e, ir, dr, dw;
            logic [31:0] ia, da, dd;
            logic        g_if, g_dm, x_ifv, x_dmv;
            logic [31:0] x_addr, x_wd, x_ifd, x_dmd;
            @(posedge clk); #1;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 99) < 85);
            ir = ($urandom_range(0, 99) < 70);
            dr = ($urandom_range(0, 99) < 50);
            dw = ($urandom_range(0, 99) < 40);
            ia = $urandom & 32'hFFFF_FFFC;
            da = $urandom & 32'hFFFF_FFFC;
            dd = $urandom;
            drive(r, e, ir, ia, dr, dw, da, dd);
            #1;
            g_dm = !r && e && dr && !(ir && m_starve == LIMIT);
            g_if = !r && e && ir && !g_dm;
            x_addr = g_dm ? da : (g_if ? ia : 32'h0);
            x_wd   = g_dm ? dd : 32'h0;
            x_ifv  = !r && (m_pend == 1);
            x_dmv  = !r && (m_pend == 2);
            x_ifd  = x_ifv ? m_pend_data : m_if_data;
            x_dmd  = x_dmv ? m_pend_data : m_dm_data;
            compare_all($sformatf("rnd%0d", c), ir && !g_if, dr && !g_dm, x_addr, x_wd,
                        g_dm && dw, x_ifv, x_dmv, !r, x_ifd, x_dmd);
            $display("rnd %0d: rst=%0b ena=%0b ifr=%0b dmr=%0b wr=%0b addr=%h if_rv=%0b dm_rv=%0b",
                     c, r, e, ir, dr, dw, mem_addr, if_rvalid, dm_rvalid);
            if (r) begin
                m_pend = 0; m_starve = 0; m_if_data = '0; m_dm_data = '0;
            end else begin
                m_if_data = x_ifd;
                m_dm_data = x_dmd;
                m_pend = g_if ? 1 : ((g_dm && !dw) ? 2 : 0);
                m_pend_data = shadow[x_addr[9:2]];
                if (g_dm && dw) shadow[da[9:2]] = dd;
                if (e) m_starve = (!ir || g_if) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
